// File: rtl/tiny_mips_pkg.sv
// Shared definitions for the tiny_mips core: opcodes, FSM encoding,
// instruction field positions and immediate extension helpers.
package tiny_mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_MUL  = 4'h2,
        OP_SRL  = 4'h3,
        OP_LD   = 4'h4,
        OP_ST   = 4'h5,
        OP_CP   = 4'h6,
        OP_CPI  = 4'h7,
        OP_BEQ  = 4'h8,
        OP_BLT  = 4'h9,
        OP_BGT  = 4'hA,
        OP_HALT = 4'hF
    } opcode_t;

    localparam int OP_LSB = 12;
    localparam int RD_LSB = 9;
    localparam int RS_LSB = 6;
    localparam int RT_LSB = 3;

    // Extension helpers produce the widest supported word; callers cast down to DW/AW.
    localparam int EXT_W = 64;

    function automatic logic [3:0] f_op(input logic [15:0] ir);
        return ir[OP_LSB +: 4];
    endfunction

    function automatic logic [2:0] f_rd(input logic [15:0] ir);
        return ir[RD_LSB +: 3];
    endfunction

    function automatic logic [2:0] f_rs(input logic [15:0] ir);
        return ir[RS_LSB +: 3];
    endfunction

    function automatic logic [2:0] f_rt(input logic [15:0] ir);
        return ir[RT_LSB +: 3];
    endfunction

    function automatic logic [EXT_W-1:0] sext6(input logic [15:0] ir);
        return {{(EXT_W-6){ir[5]}}, ir[5:0]};
    endfunction

    function automatic logic [EXT_W-1:0] zext9(input logic [15:0] ir);
        return {{(EXT_W-9){1'b0}}, ir[8:0]};
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return op inside {OP_BEQ, OP_BLT, OP_BGT};
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op inside {[4'hB:4'hE]};
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return op inside {OP_ADD, OP_ADDI, OP_MUL, OP_SRL, OP_CP, OP_CPI};
    endfunction

endpackage

// File: rtl/tiny_mips_if.sv
// Shared instruction/data memory port with request/acknowledge handshake.
interface tiny_mips_if #(
    parameter int DW = 16,
    parameter int AW = 8
) ();
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/tiny_mips_rf.sv
// 8 x DW register file: two asynchronous read ports, one synchronous write
// port, synchronous clear.
module tiny_mips_rf #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    ra_a,
    input  logic [2:0]    ra_b,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b,
    input  logic          we,
    input  logic [2:0]    wa,
    input  logic [DW-1:0] wd
);
    logic [7:0][DW-1:0] regs;

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (we)
            regs[wa] <= wd;
    end

    assign rd_a = regs[ra_a];
    assign rd_b = regs[ra_b];
endmodule

// File: rtl/tiny_mips_core.sv
// Multi-cycle 16-bit-ISA core with generic data/address width, one shared
// memory port with wait-state handshake, HALT and illegal-opcode trap.
module tiny_mips_core
    import tiny_mips_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        rst,
    tiny_mips_if.master bus,
    output logic        halted,
    output logic        illegal
);
    localparam logic [DW-1:0] SHIFT_LIM = DW'(DW);

    state_t        state, state_nx;
    logic [AW-1:0] pc, pc_nx, ea, off6;
    logic [15:0]   ir;
    logic [DW-1:0] t1, t2, alu_y, rf_qa, rf_qb, rf_wd;
    logic [3:0]    op;
    logic [2:0]    rd, rs, rt, ra_a, ra_b;
    logic          use_rd, br_take, rf_we, ill_q;

    assign op   = f_op(ir);
    assign rd   = f_rd(ir);
    assign rs   = f_rs(ir);
    assign rt   = f_rt(ir);
    assign off6 = AW'(sext6(ir));

    // Branches and ST take rd as their first operand instead of rs/rt.
    assign use_rd = is_branch(op) || (op == OP_ST);
    assign ra_a   = use_rd ? rd : rs;
    assign ra_b   = use_rd ? rs : rt;

    tiny_mips_rf #(.DW(DW)) u_rf (
        .clk  (clk),
        .rst  (rst),
        .ra_a (ra_a),
        .ra_b (ra_b),
        .rd_a (rf_qa),
        .rd_b (rf_qb),
        .we   (rf_we),
        .wa   (rd),
        .wd   (rf_wd)
    );

    always_comb begin
        alu_y = '0;
        case (op)
            OP_ADD:  alu_y = t1 + t2;
            OP_ADDI: alu_y = t1 + DW'(sext6(ir));
            OP_MUL:  alu_y = t1 * t2;
            OP_SRL:  alu_y = (t2 >= SHIFT_LIM) ? '0 : (t1 >> t2);
            OP_CP:   alu_y = t1;
            OP_CPI:  alu_y = DW'(zext9(ir));
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        br_take = 1'b0;
        case (op)
            OP_BEQ:  br_take = (t1 == t2);
            OP_BLT:  br_take = (t1 <  t2);
            OP_BGT:  br_take = (t1 >  t2);
            default: br_take = 1'b0;
        endcase
    end

    // Bus outputs depend on state only; mem_ack steers next state and writes.
    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        rf_we         = 1'b0;
        rf_wd         = alu_y;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = pc;
                if (bus.mem_ack)
                    state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_HALT || is_illegal(op))
                    state_nx = S_HALT;
                else
                    state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (writes_rd(op)) begin
                    rf_we    = 1'b1;
                    pc_nx    = pc + AW'(1);
                    state_nx = S_FETCH;
                end else if (is_branch(op)) begin
                    pc_nx    = br_take ? pc + off6 : pc + AW'(1);
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_MEM;
                end
            end
            S_MEM: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = ea;
                bus.mem_we    = (op == OP_ST);
                bus.mem_wdata = (op == OP_ST) ? t1 : '0;
                if (bus.mem_ack) begin
                    rf_we    = (op == OP_LD);
                    rf_wd    = bus.mem_rdata;
                    pc_nx    = pc + AW'(1);
                    state_nx = S_FETCH;
                end
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_FETCH;
        endcase
        // Reset abandons any pending request immediately.
        if (rst) begin
            bus.mem_req   = 1'b0;
            bus.mem_we    = 1'b0;
            bus.mem_addr  = '0;
            bus.mem_wdata = '0;
            rf_we         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            ir    <= '0;
            t1    <= '0;
            t2    <= '0;
            ea    <= '0;
            ill_q <= 1'b0;
        end else begin
            pc <= pc_nx;
            if (state == S_FETCH && bus.mem_ack)
                ir <= bus.mem_rdata[15:0];
            if (state == S_DECODE) begin
                t1    <= rf_qa;
                t2    <= rf_qb;
                ill_q <= is_illegal(op);
            end
            if (state == S_EXEC)
                ea <= AW'((op == OP_ST) ? t2 : t1) + off6;
        end
    end

    assign halted  = (state == S_HALT);
    assign illegal = ill_q;
endmodule

// File: tb/tb_tiny_mips_core.sv
// Directed bench for tiny_mips_core (DW=32, AW=8) with a wait-state memory model
// serviced one cycle at a time from the stimulus thread.
module tb_tiny_mips_core;
    localparam int DW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    logic halted, illegal;

    tiny_mips_if #(.DW(DW), .AW(AW)) bus ();

    tiny_mips_core #(.DW(DW), .AW(AW)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .halted  (halted),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];
    int            checks = 0;
    int            failures = 0;
    int            delay = 0;
    int            wcnt = 0;
    int            n;
    logic          p_wait = 1'b0;
    logic [AW-1:0] p_addr;
    logic          p_we;
    logic [DW-1:0] p_wd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [5:0] lo);
        return {op, rd, rs, lo};
    endfunction

    function automatic logic [15:0] cpi(input logic [2:0] rd, input logic [8:0] imm);
        return {4'h7, rd, imm};
    endfunction

    // Upper half of every instruction word is junk the core must ignore.
    task automatic put(input int a, input logic [15:0] w);
        mem[a] = {16'hDEAD, w};
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        #1;
    endtask

    // One clock of memory service: answer the request seen now, commit writes at the edge.
    task automatic cyc();
        logic reqd, acked, do_wr;
        reqd = !rst && bus.mem_req;
        if (!reqd) begin
            wcnt = 0;
            bus.mem_ack = 1'b0;
            p_wait = 1'b0;
        end else begin
            if (p_wait) begin
                chk("hold_addr",  bus.mem_addr,  p_addr);
                chk("hold_we",    bus.mem_we,    p_we);
                chk("hold_wdata", bus.mem_wdata, p_wd);
            end
            bus.mem_ack   = (wcnt >= delay);
            bus.mem_rdata = mem[bus.mem_addr];
            p_wait = !bus.mem_ack;
            p_addr = bus.mem_addr;
            p_we   = bus.mem_we;
            p_wd   = bus.mem_wdata;
        end
        acked = reqd && bus.mem_ack;
        do_wr = acked && bus.mem_we;
        @(posedge clk);
        if (do_wr) mem[p_addr] = p_wd;
        if (acked) wcnt = 0;
        else if (reqd) wcnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_rst(1'b1);
        cyc();
        cyc();
        set_rst(1'b0);
    endtask

    task automatic run_halt(input int limit, output int cnt);
        cnt = 0;
        while (!halted && cnt < limit) begin
            cyc();
            cnt++;
        end
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // Reset state and simple ALU program, zero-wait memory
        delay = 0;
        clear_mem();
        put(0, cpi(3'd1, 9'd5));
        put(1, cpi(3'd2, 9'd7));
        put(2, ins(4'h0, 3'd3, 3'd1, {3'd2, 3'd0}));
        put(3, 16'hF000);
        set_rst(1'b1);
        chk("rst_req_async", bus.mem_req, 1'b0);
        cyc();
        cyc();
        chk("rst_req",     bus.mem_req,   1'b0);
        chk("rst_we",      bus.mem_we,    1'b0);
        chk("rst_addr",    bus.mem_addr,  0);
        chk("rst_wdata",   bus.mem_wdata, 0);
        chk("rst_halted",  halted,        1'b0);
        chk("rst_illegal", illegal,       1'b0);
        chk("rst_pc",      u_dut.pc,      0);
        chk("rst_ir",      u_dut.ir,      0);
        for (int i = 0; i < 8; i++) chk("rst_rf", u_dut.u_rf.regs[i], 0);
        set_rst(1'b0);
        chk("fetch0_req",  bus.mem_req,  1'b1);
        chk("fetch0_addr", bus.mem_addr, 0);
        run_halt(100, n);
        chk("add_cycles",  n, 11);
        chk("add_r3",      u_dut.u_rf.regs[3], 12);
        chk("add_illegal", illegal, 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        chk("halt_req",    bus.mem_req, 1'b0);
        chk("halt_stays",  halted, 1'b1);

        // LD/ST with three wait states per access
        delay = 3;
        clear_mem();
        mem[8'h1F] = 32'hCAFE_0001;
        put(0, cpi(3'd1, 9'h020));
        put(1, ins(4'h5, 3'd1, 3'd1, 6'd2));
        put(2, ins(4'h4, 3'd4, 3'd1, 6'd2));
        put(3, ins(4'h4, 3'd5, 3'd1, 6'h3F));
        put(4, 16'hF000);
        do_reset();
        run_halt(300, n);
        chk("ldst_cycles", n, 41);
        chk("st_mem22",    mem[8'h22], 32'h20);
        chk("ld_r4",       u_dut.u_rf.regs[4], 32'h20);
        chk("ld_neg_r5",   u_dut.u_rf.regs[5], 32'hCAFE_0001);

        // BEQ taken backwards
        delay = 0;
        clear_mem();
        put(0,  cpi(3'd1, 9'd3));
        put(1,  cpi(3'd2, 9'd3));
        put(2,  ins(4'h8, 3'd0, 3'd0, 6'd8));
        put(10, ins(4'h8, 3'd1, 3'd2, 6'h3E));
        put(8,  cpi(3'd6, 9'h1AB));
        put(9,  16'hF000);
        put(11, cpi(3'd6, 9'h0EE));
        put(12, 16'hF000);
        do_reset();
        run_halt(200, n);
        chk("beq_cycles", n, 17);
        chk("beq_r6",     u_dut.u_rf.regs[6], 32'h1AB);
        chk("beq_pc",     u_dut.pc, 9);

        // BLT/BGT taken and not taken, unsigned compare
        clear_mem();
        put(0,  cpi(3'd1, 9'd5));
        put(1,  cpi(3'd2, 9'd3));
        put(2,  ins(4'h1, 3'd7, 3'd0, 6'h3F));
        put(3,  ins(4'h8, 3'd0, 3'd0, 6'd7));
        put(10, ins(4'h9, 3'd1, 3'd2, 6'h3E));
        put(11, ins(4'hA, 3'd1, 3'd2, 6'd3));
        put(14, ins(4'h9, 3'd2, 3'd1, 6'd2));
        put(16, ins(4'hA, 3'd7, 3'd1, 6'd4));
        put(20, 16'hF000);
        do_reset();
        run_halt(200, n);
        chk("br_cycles", n, 26);
        chk("br_pc",     u_dut.pc, 20);

        // Branch to 0xFF and PC increment wrap back to 0x00
        clear_mem();
        put(0,     ins(4'h8, 3'd5, 3'd0, 6'h3F));
        put(8'hFF, cpi(3'd5, 9'h055));
        put(1,     16'hF000);
        do_reset();
        run_halt(100, n);
        chk("wrap_cycles", n, 11);
        chk("wrap_r5",     u_dut.u_rf.regs[5], 32'h55);
        chk("wrap_pc",     u_dut.pc, 1);

        // 32-bit width rules, one wait state per access
        delay = 1;
        clear_mem();
        put(0,  ins(4'h1, 3'd1, 3'd0, 6'h3F));
        put(1,  cpi(3'd2, 9'h100));
        put(2,  ins(4'h2, 3'd3, 3'd2, {3'd2, 3'd0}));
        put(3,  ins(4'h2, 3'd4, 3'd3, {3'd3, 3'd0}));
        put(4,  cpi(3'd5, 9'd32));
        put(5,  cpi(3'd6, 9'h080));
        put(6,  ins(4'h3, 3'd7, 3'd6, {3'd5, 3'd0}));
        put(7,  cpi(3'd5, 9'd4));
        put(8,  ins(4'h3, 3'd5, 3'd6, {3'd5, 3'd0}));
        put(9,  ins(4'h0, 3'd6, 3'd1, {3'd6, 3'd0}));
        put(10, ins(4'h6, 3'd2, 3'd1, 6'd0));
        put(11, 16'hF000);
        do_reset();
        run_halt(300, n);
        chk("w_cycles",  n, 47);
        chk("addi_neg1", u_dut.u_rf.regs[1], 32'hFFFF_FFFF);
        chk("mul_small", u_dut.u_rf.regs[3], 32'h0001_0000);
        chk("mul_wrap",  u_dut.u_rf.regs[4], 32'h0);
        chk("srl_ge_dw", u_dut.u_rf.regs[7], 32'h0);
        chk("srl_4",     u_dut.u_rf.regs[5], 32'h8);
        chk("add_wrap",  u_dut.u_rf.regs[6], 32'h7F);
        chk("cp_r2",     u_dut.u_rf.regs[2], 32'hFFFF_FFFF);

        // Illegal opcodes, then reset recovery
        delay = 0;
        clear_mem();
        put(0, cpi(3'd1, 9'd9));
        put(1, 16'hC123);
        do_reset();
        run_halt(100, n);
        chk("ill_cycles",  n, 5);
        chk("ill_flag",    illegal, 1'b1);
        for (int i = 0; i < 4; i++) cyc();
        chk("ill_req",     bus.mem_req, 1'b0);
        chk("ill_halted",  halted, 1'b1);
        set_rst(1'b1);
        cyc();
        chk("ill_rst_halted",  halted, 1'b0);
        chk("ill_rst_illegal", illegal, 1'b0);
        chk("ill_rst_r1",      u_dut.u_rf.regs[1], 0);
        set_rst(1'b0);
        chk("ill_refetch_req",  bus.mem_req, 1'b1);
        chk("ill_refetch_addr", bus.mem_addr, 0);
        put(0, 16'hB000);
        run_halt(100, n);
        chk("illB_cycles", n, 2);
        chk("illB_flag",   illegal, 1'b1);

        // Reset in the middle of a stalled ST
        delay = 20;
        clear_mem();
        put(0, cpi(3'd1, 9'h030));
        put(1, ins(4'h5, 3'd1, 3'd1, 6'd0));
        do_reset();
        for (int i = 0; i < 200 && !(bus.mem_req && bus.mem_we); i++) cyc();
        chk("st_wait_we", bus.mem_we, 1'b1);
        for (int i = 0; i < 3; i++) cyc();
        chk("st_wait_addr",  bus.mem_addr, 8'h30);
        chk("st_wait_wdata", bus.mem_wdata, 32'h30);
        set_rst(1'b1);
        chk("st_rst_req", bus.mem_req, 1'b0);
        chk("st_rst_we",  bus.mem_we, 1'b0);
        cyc();
        set_rst(1'b0);
        chk("st_no_write",  mem[8'h30], 0);
        chk("st_refetch_req",  bus.mem_req, 1'b1);
        chk("st_refetch_addr", bus.mem_addr, 0);
        chk("st_refetch_we",   bus.mem_we, 1'b0);
        for (int i = 0; i < 8; i++) chk("st_rst_rf", u_dut.u_rf.regs[i], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
